// File: rtl/rr_mux4x1.sv
// Four-channel round-robin mux onto one registered valid/ready output stream.
// Latency: one cycle from input handshake to out_valid; one word per cycle sustained.
// Backpressure: out_ready low with a word held stalls the output, and in_ready is all zero.
module rr_mux4x1 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           in_valid,
  input  logic [4*WIDTH-1:0]   in_data,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  input  logic                 out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic       ld;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  assign out_valid = (state == FULL);

  // An empty register always loads; a full one loads only as it drains.
  assign ld = (state == EMPTY) || out_ready;

  // Walk from the farthest offset to the nearest so the channel right after
  // last_grant wins; offset 4 wraps onto last_grant itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int off = 4; off >= 1; off--) begin
      cand = last_grant + off[1:0];
      if (in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign in_ready = (grant_vld && ld) ? (4'b0001 << grant_idx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_sel    <= 2'b00;
      last_grant <= 2'b11;
    end else if (ld) begin
      if (grant_vld) begin
        state      <= FULL;
        out_data   <= in_data[grant_idx*WIDTH +: WIDTH];
        out_sel    <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4x1.sv
// Directed bench for rr_mux4x1: expected words queued at drive time, popped at output.
module tb_rr_mux4x1;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  rr_mux4x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 2-to-4 decoder: x1 = out_sel[1], x2 = out_sel[0], index k raises yk.
  function automatic logic [3:0] dec2to4(input logic x1, input logic x2);
    logic [3:0] one;
    one = 4'b0001;
    return one << {x1, x2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check in_ready before the edge, then after the
  // edge pop and compare the loaded word whenever a handshake was expected.
  task automatic cycle(input string tag, input logic r, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy, input logic [3:0] exp_rdy);
    logic [9:0] e;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (exp_rdy != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_sel"},   32'(out_sel),   32'(e[9:8]));
        chk({tag, ".out_data"},  32'(out_data),  32'(e[7:0]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0000; in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data",  32'(out_data),  32'd0);
    chk("reset.out_sel",   32'(out_sel),   32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd0);

    // Reset priority and fairness: all four valid, grants 0,1,2,3,0.
    exp_q.push_back({2'd0, 8'h11}); cycle("rr0", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001);
    exp_q.push_back({2'd1, 8'h22}); cycle("rr1", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0010);
    exp_q.push_back({2'd2, 8'h33}); cycle("rr2", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0100);
    exp_q.push_back({2'd3, 8'h44}); cycle("rr3", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b1000);
    exp_q.push_back({2'd0, 8'h11}); cycle("rr4", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001);

    // Decoder link: channel 2 alone carrying A5.
    exp_q.push_back({2'd2, 8'hA5}); cycle("dec", 1'b0, 4'b0100, 32'h00A50000, 1'b1, 4'b0100);
    chk("dec.y", 32'(dec2to4(out_sel[1], out_sel[0])), 32'(4'b0100));

    // Backpressure: word 3C from channel 1 held for 4 stalled cycles.
    exp_q.push_back({2'd1, 8'h3C}); cycle("bp_load", 1'b0, 4'b0010, 32'h00003C00, 1'b1, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      cycle("bp_stall", 1'b0, 4'b1011, 32'hD300B1B0, 1'b0, 4'b0000);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.out_data",  32'(out_data),  32'h3C);
      chk("bp.out_sel",   32'(out_sel),   32'd1);
    end
    exp_q.push_back({2'd3, 8'hD3}); cycle("bp_rel3", 1'b0, 4'b1011, 32'hD300B1B0, 1'b1, 4'b1000);
    exp_q.push_back({2'd0, 8'hB0}); cycle("bp_rel0", 1'b0, 4'b1011, 32'hD300B1B0, 1'b1, 4'b0001);

    // Idle and bubble: one word on channel 0, then nothing.
    exp_q.push_back({2'd0, 8'hC0}); cycle("idle_w", 1'b0, 4'b0001, 32'h000000C0, 1'b1, 4'b0001);
    cycle("idle1", 1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("idle1.out_valid", 32'(out_valid), 32'd0);
    cycle("idle2", 1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("idle2.out_valid", 32'(out_valid), 32'd0);

    // Reset while a channel-2 word is stalled at the output.
    exp_q.push_back({2'd2, 8'hE2}); cycle("mid_load", 1'b0, 4'b0100, 32'h00E20000, 1'b1, 4'b0100);
    cycle("mid_rst", 1'b1, 4'b1111, 32'h44332211, 1'b0, 4'b0000);
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_sel",   32'(out_sel),   32'd0);
    chk("mid_rst.out_data",  32'(out_data),  32'd0);
    exp_q.push_back({2'd0, 8'h11}); cycle("post_rst", 1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001);

    // Single-source streaming on channel 3 with no bubbles.
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({2'd3, 8'(k)});
      cycle("stream", 1'b0, 4'b1000, {8'(k), 24'h0}, 1'b1, 4'b1000);
    end
    cycle("drain", 1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("scoreboard.left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux4x1.md
Name: rr_mux4x1

Overview:
- Four-channel round-robin multiplexer with valid/ready handshakes on every channel.
- Merges four source channels onto one registered output stream.
- Tags each output word with a 2-bit channel index `out_sel`. That encoding drives the downstream 2-to-4 decoder/demultiplexer: `out_sel[1]` maps to x1 and `out_sel[0]` maps to x2, so index k selects yk.
- Together the two blocks form a mux/demux pair over a shared link.

Parameters:
- WIDTH, 8: data width of each channel and of the output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel ready. Combinational; at most one bit high per cycle.
- out_valid  output  1  the output register holds a word.
- out_data  output  WIDTH  registered data word.
- out_sel  output  2  registered index of the source channel of `out_data`.
- out_ready  input  1  downstream accepts the word when high together with `out_valid`.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset `rst` is synchronous and active-high.
  - On `rst` at a clock edge: `out_valid`=0, `out_data`=0, `out_sel`=2'b00, `last_grant`=2'b11, so channel 0 has first priority.
  - `rst` dominates all other inputs in that cycle.
  - A word held at the output when reset occurs is discarded; no handshake completes in the reset cycle.
- State machine, two states encoded by `out_valid`:
  - EMPTY (`out_valid`=0): load enable `ld`=1.
  - FULL (`out_valid`=1): `ld` = `out_ready`. This allows drain-and-refill in the same cycle.
- Arbitration, combinational, evaluated every cycle:
  - Search channels in order `last_grant`+1, +2, +3, +4 (mod 4).
  - The first channel with `in_valid` high is the grant g.
  - No `in_valid` high: no grant.
- Ready:
  - `in_ready[g]` = `ld`; all other `in_ready` bits are 0.
  - With no grant, `in_ready` = 4'b0000.
  - `in_ready` does not depend on `in_data`.
- Transfer:
  - On a clock edge with a grant g and `ld`=1: `out_data` <= channel g data, `out_sel` <= g, `out_valid` <= 1, `last_grant` <= g.
  - On a clock edge with `ld`=1 and no grant: `out_valid` <= 0. `out_data` and `out_sel` hold their previous values (don't-care).
  - On a clock edge with `ld`=0: all state holds.
- Latency and throughput:
  - Latency is one cycle from input handshake to `out_valid`.
  - Sustained throughput is one word per cycle while `out_ready` stays high.
- Backpressure:
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_sel` and `out_valid` are stable.
  - `in_ready` is all zero during backpressure.
  - `last_grant` is unchanged during backpressure.
- Fairness:
  - With all four channels continuously valid and `out_ready`=1, grants are 0,1,2,3,0,... (after reset).
  - No channel waits more than 3 transfers once valid.
- Source-side rules:
  - A source must hold `in_valid` and `in_data` until its handshake. The block does not check this.
  - A source dropping `in_valid` before its grant is simply skipped.
- Simultaneous events: drain and load in the same cycle is one atomic register update, with no bubble.
- Wrap-around: `last_grant`=3 searches 0,1,2,3.
- A single active channel gets back-to-back grants every cycle.

Test Plan:
- Reset priority: apply `rst` for 2 cycles, then `in_valid`=4'b1111, `out_ready`=1 → `in_ready` = 0001, 0010, 0100, 1000, 0001 on successive cycles; `out_sel` = 0,1,2,3,0, one cycle later.
- Decoder link: drive `out_sel` into the 2-to-4 decoder with channel 2 only valid and data 8'hA5 → one cycle later `out_valid`=1, `out_data`=8'hA5, `out_sel`=2'b10 (x1=1, x2=0), decoder output y2=1 and the other three outputs 0.
- Backpressure:
  - Channel 1 with data 8'h3C transfers.
  - Then `out_ready`=0 for 4 cycles while `in_valid`=4'b1011 → `out_data`=8'h3C and `out_sel`=1 stable, `in_ready`=0000.
  - On `out_ready`=1 the next grant is channel 3, then channel 0.
- Idle and bubble: a single word on channel 0, then `in_valid`=0 with `out_ready`=1 → `out_valid` goes 1 for one cycle, then 0; `in_ready` stays 0000 while idle.
- Reset mid-operation: `out_valid`=1 and `out_ready`=0 with `last_grant`=2, then assert `rst` → next cycle `out_valid`=0 and `out_sel`=0; with all channels valid the first grant after reset is channel 0.
- Single-source streaming: channel 3 only valid with data 1,2,3,4 and `out_ready`=1 → `out_data` = 1,2,3,4 on consecutive cycles, `out_sel`=3 throughout, no bubbles.
